ds_temp_ctrl: RTL

- Command-level sequencer for the DS18B20 1-wire bit interface (reset / write-bit / read-bit slot engine with `rdy` handshake).
- On a `start` pulse it runs one full temperature acquisition: reset, Skip ROM, Convert T, conversion wait, reset, Skip ROM, Read Scratchpad, then 16 read slots.
- It returns the raw 16-bit temperature word with a one-cycle valid strobe.
- It sits between the temperature-display/control logic and the bit interface, and is that interface's only master.

---
 rtl/ds_temp_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ds_temp_ctrl.sv
// ds_temp_ctrl: command-level sequencer for a DS18B20 on top of a 1-wire bit
// slot engine. A start pulse runs one full acquisition (reset, Skip ROM,
// Convert T, conversion wait, reset, Skip ROM, Read Scratchpad, 16 read slots).
// The raw 16-bit temperature word is then presented with a one-cycle strobe.
//
// Handshake with the bit interface: bit_rdy high means the interface is idle
// and will accept a request. A request (bit_rst_en / bit_wr_en / bit_rd_en) is
// a registered single-cycle pulse. It is raised only when bit_rdy was high in
// the previous cycle and no request was high in that cycle. After a request
// the sequencer waits for the next bit_rdy high, ignoring the request cycle
// itself, before it moves on. At most one request is high in any cycle.
module ds_temp_ctrl #(
    parameter int unsigned TIME_CONV    = 37_500_000,
    parameter logic [7:0]  CMD_SKIP_ROM = 8'hCC,
    parameter logic [7:0]  CMD_CONVERT  = 8'h44,
    parameter logic [7:0]  CMD_READ_SP  = 8'hBE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic [15:0] temp_data,
    output logic        temp_vld,
    output logic        bit_rst_en,
    output logic        bit_wr_en,
    output logic        bit_wdata,
    output logic        bit_rd_en,
    input  logic        bit_rdata,
    input  logic        bit_rdata_vld,
    input  logic        bit_rdy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT      = 3'd2,
        S_CONV_WAIT = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [2:0]  STEP_READ = 3'd7;
    localparam logic [31:0] CONV_LAST = 32'(TIME_CONV - 1);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  step_q;
    logic [3:0]  bit_cnt_q;
    logic [15:0] shift_q;
    logic [15:0] shift_nxt;
    logic [31:0] conv_cnt_q;
    logic        rst_en_q;
    logic        wr_en_q;
    logic        wdata_q;
    logic        rd_en_q;
    logic [15:0] temp_q;

    logic        step_is_rst;
    logic        step_is_wr;
    logic        step_is_rd;
    logic        step_is_conv;
    logic [7:0]  step_cmd;
    logic [3:0]  last_bit;

    logic        req_any;
    logic        issue_fire;
    logic        slot_done;
    logic        bit_last;
    logic        conv_term;
    logic        read_done;

    // Decode what the current step asks the bit interface to do.
    always_comb begin
        step_is_rst  = 1'b0;
        step_is_wr   = 1'b0;
        step_is_rd   = 1'b0;
        step_is_conv = 1'b0;
        step_cmd     = 8'h00;
        last_bit     = 4'd0;
        case (step_q)
            3'd0, 3'd4: begin
                step_is_rst = 1'b1;
                last_bit    = 4'd0;
            end
            3'd1, 3'd5: begin
                step_is_wr = 1'b1;
                step_cmd   = CMD_SKIP_ROM;
                last_bit   = 4'd7;
            end
            3'd2: begin
                step_is_wr = 1'b1;
                step_cmd   = CMD_CONVERT;
                last_bit   = 4'd7;
            end
            3'd6: begin
                step_is_wr = 1'b1;
                step_cmd   = CMD_READ_SP;
                last_bit   = 4'd7;
            end
            3'd3: begin
                step_is_conv = 1'b1;
            end
            default: begin
                step_is_rd = 1'b1;
                last_bit   = 4'd15;
            end
        endcase
    end

    // Handshake qualifiers; the request cycle never counts as a ready sample.
    always_comb begin
        req_any    = rst_en_q | wr_en_q | rd_en_q;
        issue_fire = (state_q == S_ISSUE) && !step_is_conv && bit_rdy && !req_any;
        slot_done  = (state_q == S_WAIT) && bit_rdy && !req_any;
        bit_last   = (bit_cnt_q == last_bit);
        conv_term  = (state_q == S_CONV_WAIT) && (conv_cnt_q == CONV_LAST);
        read_done  = slot_done && bit_last && (step_q == STEP_READ);
        shift_nxt  = (bit_rdata_vld && (step_q == STEP_READ))
                   ? {bit_rdata, shift_q[15:1]} : shift_q;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (step_is_conv)    state_d = S_CONV_WAIT;
                else if (issue_fire) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (read_done)      state_d = S_DONE;
                else if (slot_done) state_d = S_ISSUE;
            end
            S_CONV_WAIT: begin
                if (conv_term) state_d = S_ISSUE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic; slot requests come straight from their registers.
    always_comb begin
        busy       = (state_q != S_IDLE);
        temp_vld   = (state_q == S_DONE);
        temp_data  = temp_q;
        bit_rst_en = rst_en_q;
        bit_wr_en  = wr_en_q;
        bit_wdata  = wdata_q;
        bit_rd_en  = rd_en_q;
    end

    // Registered slot requests, one cycle wide, LSB-first command bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            wdata_q  <= 1'b0;
            rd_en_q  <= 1'b0;
        end else begin
            rst_en_q <= issue_fire && step_is_rst;
            wr_en_q  <= issue_fire && step_is_wr;
            wdata_q  <= issue_fire && step_is_wr && step_cmd[bit_cnt_q[2:0]];
            rd_en_q  <= issue_fire && step_is_rd;
        end
    end

    // Step and bit counters walk the fixed command list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q    <= 3'd0;
            bit_cnt_q <= 4'd0;
        end else if ((state_q == S_IDLE) && start) begin
            step_q    <= 3'd0;
            bit_cnt_q <= 4'd0;
        end else if (slot_done) begin
            if (bit_last) begin
                bit_cnt_q <= 4'd0;
                step_q    <= step_q + 3'd1;
            end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
        end else if (conv_term) begin
            step_q <= step_q + 3'd1;
        end
    end

    // Conversion timer: cleared on entry, counts 0..TIME_CONV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_cnt_q <= 32'd0;
        end else if ((state_q == S_ISSUE) && step_is_conv) begin
            conv_cnt_q <= 32'd0;
        end else if (state_q == S_CONV_WAIT) begin
            conv_cnt_q <= conv_cnt_q + 32'd1;
        end
    end

    // Read capture (LSB first) and the held result word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 16'h0000;
            temp_q  <= 16'h0000;
        end else begin
            shift_q <= shift_nxt;
            if (read_done) temp_q <= shift_nxt;
        end
    end

endmodule
